calib_sequencer: RTL and testbench
==================================

Name: calib_sequencer

Overview:
- Drives the HSV threshold calibration flow for AirPong. Steps the user through PUCK, PADDLE1 and PADDLE2 in turn: seed the thresholds, tune H, S and V, then commit.
- Generates the obj_sel, update_value, enable_threshold and pulsed button controls consumed by the threshold-update datapath. Adds auto-repeat for held adjust buttons.
- Emits a commit strobe per object so a downstream bank can latch the threshold set.

Parameters:
- REPEAT_DELAY, 16250000, cycles an adjust button is held before auto-repeat starts (0.25 s at 65 MHz).
- REPEAT_RATE, 4875000, cycles between auto-repeat pulses after REPEAT_DELAY.
- CNT_W, 25, width of the shared hold counter; must hold max(REPEAT_DELAY, REPEAT_RATE).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- btn_start_pulsed  in  1  one-cycle start/recalibrate request
- btn_enter_pulsed  in  1  one-cycle enter
- btn_next_pulsed  in  1  one-cycle next-channel
- btn_cancel_pulsed  in  1  one-cycle abort
- adj_level  in  4  debounced held levels [0]=min_incr [1]=min_decr [2]=max_incr [3]=max_decr
- obj_sel  out  2  channel: H=0, S=1, V=2
- target  out  2  object: PUCK=0, PADDLE1=1, PADDLE2=2
- enable_threshold  out  1  threshold updater enabled
- update_value  out  1  updater may write
- enter_out  out  1  seed pulse to updater
- min_incr_out, min_decr_out, max_incr_out, max_decr_out  out  1 each  adjust pulses to updater
- commit_strobe  out  1  one-cycle commit of current target
- calib_done  out  1  all three objects committed

Behaviour:
- Reset: all outputs are registered and reset to 0. State resets to IDLE; hold counter and active-button register reset to 0.
- Latency: every output pulse appears exactly 1 cycle after the causing input pulse.
- States (3-bit):
  - IDLE: enable_threshold=0, update_value=0. btn_start → SAMPLE with target=0, obj_sel=0.
  - SAMPLE: enable_threshold=1, update_value=1. btn_enter → enter_out=1 for one cycle; next state TUNE, obj_sel=0.
  - TUNE: enable_threshold=1, update_value=1.
    - btn_next advances obj_sel 0→1→2→0 (wraps; value 3 never driven).
    - btn_enter → COMMIT. enter_out is NOT forwarded here, so the updater is not re-seeded.
  - COMMIT: occupies exactly 1 cycle; commit_strobe=1, target held.
    - Next: target==2 → DONE; otherwise target+1 → SAMPLE with obj_sel=0.
  - DONE: calib_done=1, enable_threshold=0, update_value=0. btn_start → SAMPLE with target=0 and calib_done cleared.
- Cancel: btn_cancel in SAMPLE, TUNE or DONE → IDLE.
  - No commit_strobe; target, obj_sel and calib_done all clear to 0.
  - Ignored in IDLE.
  - COMMIT always completes; a cancel arriving during COMMIT is dropped.
- Simultaneous pulses: cancel > enter > next > start; lower-priority pulses in the same cycle are dropped.
- Pulses not valid in the current state are ignored (e.g. next in SAMPLE, enter in IDLE).
- Auto-repeat (active only in TUNE):
  - Active button = lowest set index of adj_level; priority min_incr > min_decr > max_incr > max_decr.
  - When the active button changes from none or from another button: emit one pulse on its *_out and clear the counter.
  - While the same button stays active: the counter increments.
    - On reaching REPEAT_DELAY-1: emit a pulse, enter repeat mode, clear the counter.
    - In repeat mode, emit a pulse each time the counter reaches REPEAT_RATE-1, then clear it.
  - adj_level==0 → no active button, counter 0, repeat mode cleared.
  - At most one *_out is high in any cycle.
  - Leaving TUNE (enter, cancel) clears the counter, repeat mode and active button. A button still held on re-entering TUNE counts as a new press.
  - adj_level is ignored outside TUNE; *_out stays 0.
- The counter saturates, never wraps. CNT_W must satisfy 2^CNT_W > max(REPEAT_DELAY, REPEAT_RATE).
- Reset asserted mid-operation: immediate return to IDLE with all outputs 0, including any in-flight pulse.

Test Plan:
- Full pass (REPEAT_DELAY=8, REPEAT_RATE=3): start, then enter, enter for each of the 3 objects.
  - Required: 3 enter_out pulses, in SAMPLE only.
  - Required: 3 commit_strobes with target 0, 1, 2.
  - Required: calib_done=1 and enable_threshold=0 afterwards.
- Channel wrap: in TUNE, 4 btn_next pulses → obj_sel sequence 1, 2, 0, 1.
- Auto-repeat: hold adj_level=4'b0001 for 20 cycles in TUNE → min_incr_out pulses at cycle offsets 1, 9, 12, 15, 18 relative to the press (first pulse 1 cycle after the press); none after release.
- Priority/switch: hold 4'b0100, then set 4'b0101 → a fresh min_incr_out pulse immediately and the counter restarts. Same-cycle cancel+enter in TUNE → IDLE, no commit_strobe.
- Ignore/edge: adjust held in SAMPLE → no *_out pulses. Enter in IDLE → no response. Cancel during COMMIT → commit still completes and the next state is SAMPLE/DONE.
- Reset: assert rst_n=0 mid-TUNE while a button is held → all outputs 0 asynchronously. After release the FSM sits in IDLE.

Source files
------------

// File: rtl/calib_sequencer.sv
// HSV threshold calibration sequencer for AirPong: walks PUCK, PADDLE1 and PADDLE2
// through seed/tune/commit and turns held adjust levels into single and auto-repeat pulses.
module calib_sequencer #(
  parameter int unsigned REPEAT_DELAY = 16250000,
  parameter int unsigned REPEAT_RATE  = 4875000,
  parameter int unsigned CNT_W        = 25
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_start_pulsed,
  input  logic       btn_enter_pulsed,
  input  logic       btn_next_pulsed,
  input  logic       btn_cancel_pulsed,
  input  logic [3:0] adj_level,
  output logic [1:0] obj_sel,
  output logic [1:0] target,
  output logic       enable_threshold,
  output logic       update_value,
  output logic       enter_out,
  output logic       min_incr_out,
  output logic       min_decr_out,
  output logic       max_incr_out,
  output logic       max_decr_out,
  output logic       commit_strobe,
  output logic       calib_done
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SAMPLE = 3'd1,
    TUNE   = 3'd2,
    COMMIT = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] DELAY_END = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RATE_END  = CNT_W'(REPEAT_RATE - 1);

  state_t           state, state_d;
  logic [1:0]       target_d, obj_sel_d;
  logic             enter_d, commit_d, enable_d, done_d;
  logic [3:0]       adj_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             rep, rep_d;
  // active button as {valid, index}; index 0 = min_incr ... 3 = max_decr
  logic [2:0]       btn, btn_d, act;
  logic             tune_stay;

  always_comb begin
    act = 3'b000;
    if      (adj_level[0]) act = 3'b100;
    else if (adj_level[1]) act = 3'b101;
    else if (adj_level[2]) act = 3'b110;
    else if (adj_level[3]) act = 3'b111;
  end

  always_comb begin
    state_d   = state;
    target_d  = target;
    obj_sel_d = obj_sel;
    enter_d   = 1'b0;
    commit_d  = 1'b0;
    adj_d     = '0;
    cnt_d     = cnt;
    rep_d     = rep;
    btn_d     = btn;
    tune_stay = 1'b0;

    unique case (state)
      IDLE: begin
        if (btn_start_pulsed) begin
          state_d   = SAMPLE;
          target_d  = 2'd0;
          obj_sel_d = 2'd0;
        end
      end
      SAMPLE: begin
        if (btn_cancel_pulsed) begin
          state_d   = IDLE;
          target_d  = 2'd0;
          obj_sel_d = 2'd0;
        end else if (btn_enter_pulsed) begin
          enter_d   = 1'b1;
          state_d   = TUNE;
          obj_sel_d = 2'd0;
        end
      end
      TUNE: begin
        if (btn_cancel_pulsed) begin
          state_d   = IDLE;
          target_d  = 2'd0;
          obj_sel_d = 2'd0;
        end else if (btn_enter_pulsed) begin
          state_d  = COMMIT;
          commit_d = 1'b1;
        end else begin
          tune_stay = 1'b1;
          if (btn_next_pulsed) obj_sel_d = (obj_sel == 2'd2) ? 2'd0 : obj_sel + 2'd1;
        end
      end
      COMMIT: begin
        obj_sel_d = 2'd0;
        if (target == 2'd2) begin
          state_d = DONE;
        end else begin
          state_d  = SAMPLE;
          target_d = target + 2'd1;
        end
      end
      DONE: begin
        if (btn_cancel_pulsed) begin
          state_d   = IDLE;
          target_d  = 2'd0;
          obj_sel_d = 2'd0;
        end else if (btn_start_pulsed) begin
          state_d   = SAMPLE;
          target_d  = 2'd0;
          obj_sel_d = 2'd0;
        end
      end
      default: begin
        state_d   = IDLE;
        target_d  = 2'd0;
        obj_sel_d = 2'd0;
      end
    endcase

    // Repeat engine runs only while the FSM stays in TUNE; any exit wipes it.
    if (!tune_stay || !act[2]) begin
      cnt_d = '0;
      rep_d = 1'b0;
      btn_d = 3'b000;
    end else if (act != btn) begin
      adj_d = 4'b0001 << act[1:0];
      cnt_d = '0;
      rep_d = 1'b0;
      btn_d = act;
    end else if (!rep && cnt == DELAY_END) begin
      adj_d = 4'b0001 << act[1:0];
      cnt_d = '0;
      rep_d = 1'b1;
    end else if (rep && cnt == RATE_END) begin
      adj_d = 4'b0001 << act[1:0];
      cnt_d = '0;
    end else if (cnt != '1) begin
      cnt_d = cnt + 1'b1;
    end

    enable_d = (state_d == SAMPLE) || (state_d == TUNE) || (state_d == COMMIT);
    done_d   = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      target           <= 2'd0;
      obj_sel          <= 2'd0;
      enable_threshold <= 1'b0;
      update_value     <= 1'b0;
      enter_out        <= 1'b0;
      commit_strobe    <= 1'b0;
      calib_done       <= 1'b0;
      min_incr_out     <= 1'b0;
      min_decr_out     <= 1'b0;
      max_incr_out     <= 1'b0;
      max_decr_out     <= 1'b0;
      cnt              <= '0;
      rep              <= 1'b0;
      btn              <= 3'b000;
    end else begin
      state            <= state_d;
      target           <= target_d;
      obj_sel          <= obj_sel_d;
      enable_threshold <= enable_d;
      update_value     <= enable_d;
      enter_out        <= enter_d;
      commit_strobe    <= commit_d;
      calib_done       <= done_d;
      min_incr_out     <= adj_d[0];
      min_decr_out     <= adj_d[1];
      max_incr_out     <= adj_d[2];
      max_decr_out     <= adj_d[3];
      cnt              <= cnt_d;
      rep              <= rep_d;
      btn              <= btn_d;
    end
  end

endmodule

// File: tb/tb_calib_sequencer.sv
// Scoreboard bench for calib_sequencer: stimulus queues expected pulse events,
// a negedge monitor matches every pulse the DUT produces against that queue.
module tb_calib_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_start_pulsed = 1'b0, btn_enter_pulsed = 1'b0;
  logic       btn_next_pulsed = 1'b0, btn_cancel_pulsed = 1'b0;
  logic [3:0] adj_level = 4'b0000;
  logic [1:0] obj_sel, target;
  logic       enable_threshold, update_value, enter_out;
  logic       min_incr_out, min_decr_out, max_incr_out, max_decr_out;
  logic       commit_strobe, calib_done;

  calib_sequencer #(.REPEAT_DELAY(8), .REPEAT_RATE(3), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .btn_start_pulsed(btn_start_pulsed), .btn_enter_pulsed(btn_enter_pulsed),
    .btn_next_pulsed(btn_next_pulsed), .btn_cancel_pulsed(btn_cancel_pulsed),
    .adj_level(adj_level), .obj_sel(obj_sel), .target(target),
    .enable_threshold(enable_threshold), .update_value(update_value),
    .enter_out(enter_out), .min_incr_out(min_incr_out), .min_decr_out(min_decr_out),
    .max_incr_out(max_incr_out), .max_decr_out(max_decr_out),
    .commit_strobe(commit_strobe), .calib_done(calib_done)
  );

  always #5 clk = ~clk;

  localparam int K_ENTER = 0, K_MININC = 1, K_MINDEC = 2, K_MAXINC = 3, K_MAXDEC = 4, K_COMMIT = 5;
  localparam logic [3:0] B_START = 4'b0001, B_ENTER = 4'b0010, B_NEXT = 4'b0100, B_CANCEL = 4'b1000;

  typedef struct {
    int kind;
    int tgt;
    int cyc;
  } ev_t;

  ev_t sb[$];
  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    logic [5:0] p;
    p = {commit_strobe, max_decr_out, max_incr_out, min_decr_out, min_incr_out, enter_out};
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      checks++;
      errors++;
      $display("FAIL missing_event kind=%0d expected at cycle %0d, not seen by cycle %0d",
               sb[0].kind, sb[0].cyc, cyc);
      void'(sb.pop_front());
    end
    for (int k = 0; k < 6; k++) begin
      if (p[k]) begin
        checks++;
        if (sb.size() == 0 || sb[0].cyc != cyc || sb[0].kind != k) begin
          errors++;
          $display("FAIL unexpected_event kind=%0d target=%0d at cycle %0d (next expected kind=%0d cycle=%0d)",
                   k, target, cyc, (sb.size() > 0) ? sb[0].kind : -1, (sb.size() > 0) ? sb[0].cyc : -1);
        end else begin
          if (int'(target) != sb[0].tgt) begin
            errors++;
            $display("FAIL event_target kind=%0d cycle %0d got target %0d required %0d",
                     k, cyc, target, sb[0].tgt);
          end
          void'(sb.pop_front());
        end
      end
    end
  end

  task automatic expect_ev(input int kind, input int tgt, input int offs);
    ev_t e;
    e.kind = kind;
    e.tgt  = tgt;
    e.cyc  = cyc + offs;
    sb.push_back(e);
  endtask

  // Called at a negedge; drives for one posedge and returns on the following negedge.
  task automatic pulse(input logic [3:0] b);
    {btn_cancel_pulsed, btn_next_pulsed, btn_enter_pulsed, btn_start_pulsed} = b;
    @(negedge clk);
    {btn_cancel_pulsed, btn_next_pulsed, btn_enter_pulsed, btn_start_pulsed} = 4'b0000;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s got %0d required %0d", name, act, req);
    end
  endtask

  function automatic int all_outs();
    return int'({obj_sel, target, enable_threshold, update_value, enter_out, min_incr_out,
                 min_decr_out, max_incr_out, max_decr_out, commit_strobe, calib_done});
  endfunction

  initial begin
    int c;
    idle(2);
    chk("reset_outputs", all_outs(), 0);
    rst_n = 1'b1;
    idle(1);

    pulse(B_ENTER);
    idle(1);
    chk("enter_in_idle_enable", int'(enable_threshold), 0);

    pulse(B_START);
    chk("start_enable", int'(enable_threshold), 1);
    chk("start_update", int'(update_value), 1);
    chk("start_target", int'(target), 0);

    adj_level = 4'b0001;
    idle(5);
    adj_level = 4'b0000;
    pulse(B_NEXT);
    chk("next_in_sample_obj", int'(obj_sel), 0);

    expect_ev(K_ENTER, 0, 1);
    pulse(B_ENTER);

    pulse(B_NEXT); chk("wrap_1", int'(obj_sel), 1);
    pulse(B_NEXT); chk("wrap_2", int'(obj_sel), 2);
    pulse(B_NEXT); chk("wrap_3", int'(obj_sel), 0);
    pulse(B_NEXT); chk("wrap_4", int'(obj_sel), 1);

    adj_level = 4'b0001;
    expect_ev(K_MININC, 0, 1);
    expect_ev(K_MININC, 0, 9);
    expect_ev(K_MININC, 0, 12);
    expect_ev(K_MININC, 0, 15);
    expect_ev(K_MININC, 0, 18);
    idle(20);
    adj_level = 4'b0000;
    idle(6);

    adj_level = 4'b0100;
    expect_ev(K_MAXINC, 0, 1);
    idle(4);
    adj_level = 4'b0101;
    expect_ev(K_MININC, 0, 1);
    expect_ev(K_MININC, 0, 9);
    idle(10);
    adj_level = 4'b0000;
    idle(2);

    expect_ev(K_COMMIT, 0, 1);
    pulse(B_ENTER);
    idle(1);
    chk("after_commit0_target", int'(target), 1);
    chk("after_commit0_obj", int'(obj_sel), 0);
    chk("after_commit0_enable", int'(enable_threshold), 1);

    expect_ev(K_ENTER, 1, 1);
    pulse(B_ENTER);
    expect_ev(K_COMMIT, 1, 1);
    pulse(B_ENTER);
    pulse(B_CANCEL);
    chk("cancel_in_commit_target", int'(target), 2);
    chk("cancel_in_commit_enable", int'(enable_threshold), 1);

    expect_ev(K_ENTER, 2, 1);
    pulse(B_ENTER);
    expect_ev(K_COMMIT, 2, 1);
    pulse(B_ENTER);
    idle(1);
    chk("done_flag", int'(calib_done), 1);
    chk("done_enable", int'(enable_threshold), 0);
    chk("done_update", int'(update_value), 0);

    adj_level = 4'b0010;
    idle(12);
    adj_level = 4'b0000;

    pulse(B_START);
    chk("restart_done_clear", int'(calib_done), 0);
    chk("restart_target", int'(target), 0);
    expect_ev(K_ENTER, 0, 1);
    pulse(B_ENTER);
    pulse(B_NEXT);
    pulse(B_CANCEL | B_ENTER);
    idle(1);
    chk("cancel_enter_enable", int'(enable_threshold), 0);
    chk("cancel_enter_obj", int'(obj_sel), 0);
    chk("cancel_enter_done", int'(calib_done), 0);

    pulse(B_START);
    expect_ev(K_ENTER, 0, 1);
    pulse(B_ENTER);
    adj_level = 4'b1000;
    expect_ev(K_MAXDEC, 0, 1);
    idle(3);
    #1 rst_n = 1'b0;
    #1 chk("async_reset_outputs", all_outs(), 0);
    idle(2);
    chk("held_reset_outputs", all_outs(), 0);
    rst_n = 1'b1;
    idle(2);
    adj_level = 4'b0000;
    chk("post_reset_idle", int'(enable_threshold), 0);
    pulse(B_ENTER);
    chk("post_reset_enter_ignored", int'(enable_threshold), 0);
    pulse(B_START);
    chk("post_reset_start", int'(enable_threshold), 1);

    idle(3);
    c = sb.size();
    chk("scoreboard_drained", c, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
